// File: rtl/frag_issue_ctrl_pkg.sv
// Shared definitions for the fragment fetch/issue controller: opcode classes,
// controller state encoding and prefix payload widths.
package frag_issue_ctrl_pkg;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
  localparam logic [2:0] OP_TPFX = 3'b011;
  localparam logic [2:0] OP_IPFX = 3'b100;
  localparam logic [2:0] OP_FRAG = 3'b101;

  localparam int TX_W     = 16;
  localparam int IX_W     = 26;
  localparam int NALLOC_W = 6;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_ISSUE = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    CLS_BASE,
    CLS_TPFX,
    CLS_IPFX,
    CLS_FSTART,
    CLS_FEND,
    CLS_ILL
  } word_cls_t;

endpackage

// File: rtl/frag_issue_ctrl_dec.sv
// Instruction word decoder: classifies a fetched word and extracts the
// prefix payloads and the fragment-start allocation count.
module frag_issue_ctrl_dec
  import frag_issue_ctrl_pkg::*;
(
  input  logic [31:0]         word,
  output word_cls_t           cls,
  output logic [TX_W-1:0]     tx,
  output logic [IX_W-1:0]     ix,
  output logic [NALLOC_W-1:0] nalloc
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    cls = CLS_ILL;
    case (word[31:29])
      OP_ALU, OP_LD, OP_ST: cls = CLS_BASE;
      OP_TPFX:              cls = CLS_TPFX;
      OP_IPFX:              cls = CLS_IPFX;
      OP_FRAG:              cls = word[28] ? CLS_FEND : CLS_FSTART;
      default:              cls = CLS_ILL;
    endcase
  end

  assign tx     = word[TX_W-1:0];
  assign ix     = word[IX_W-1:0];
  assign nalloc = word[NALLOC_W-1:0];

endmodule

// File: rtl/frag_issue_ctrl.sv
// Fragment fetch/issue sequencer: walks instruction memory word by word,
// folds T/I prefixes into the next base word and hands bundles to the array.
module frag_issue_ctrl
  import frag_issue_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [31:0]     iss_word,
  output logic [PC_W-1:0] iss_pc,
  output logic            iss_tx_v,
  output logic [15:0]     iss_tx,
  output logic            iss_ix_v,
  output logic [25:0]     iss_ix,
  output logic            frag_start,
  output logic [5:0]      frag_nalloc,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [31:0]           word_q, word_d;
  logic [PC_W-1:0]       ipc_q, ipc_d;
  logic                  tx_v_q, tx_v_d;
  logic [TX_W-1:0]       tx_q, tx_d;
  logic                  ix_v_q, ix_v_d;
  logic [IX_W-1:0]       ix_q, ix_d;
  logic [NALLOC_W-1:0]   nalloc_q, nalloc_d;
  logic                  fstart_q, fstart_d;
  logic                  done_q, done_d;

  word_cls_t             dec_cls;
  logic [TX_W-1:0]       dec_tx;
  logic [IX_W-1:0]       dec_ix;
  logic [NALLOC_W-1:0]   dec_nalloc;

  frag_issue_ctrl_dec u_dec (
    .word   (imem_rdata),
    .cls    (dec_cls),
    .tx     (dec_tx),
    .ix     (dec_ix),
    .nalloc (dec_nalloc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    word_d   = word_q;
    ipc_d    = ipc_q;
    tx_v_d   = tx_v_q;
    tx_d     = tx_q;
    ix_v_d   = ix_v_q;
    ix_d     = ix_q;
    nalloc_d = nalloc_q;
    fstart_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = start_pc;
          tx_v_d  = 1'b0;
          ix_v_d  = 1'b0;
        end
      end

      ST_FETCH: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_WAIT;
      end

      // pc_q already points past the word being returned this cycle.
      ST_WAIT: begin
        case (dec_cls)
          CLS_BASE: begin
            word_d  = imem_rdata;
            ipc_d   = pc_q - PC_W'(1);
            state_d = ST_ISSUE;
          end
          CLS_TPFX: begin
            if (tx_v_q) begin
              state_d = ST_ERR;
            end else begin
              tx_v_d  = 1'b1;
              tx_d    = dec_tx;
              state_d = ST_FETCH;
            end
          end
          CLS_IPFX: begin
            if (ix_v_q) begin
              state_d = ST_ERR;
            end else begin
              ix_v_d  = 1'b1;
              ix_d    = dec_ix;
              state_d = ST_FETCH;
            end
          end
          CLS_FSTART: begin
            if (tx_v_q || ix_v_q) begin
              state_d = ST_ERR;
            end else begin
              fstart_d = 1'b1;
              nalloc_d = dec_nalloc;
              state_d  = ST_FETCH;
            end
          end
          CLS_FEND: begin
            if (tx_v_q || ix_v_q) begin
              state_d = ST_ERR;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_ERR;
        endcase
      end

      ST_ISSUE: begin
        if (iss_ready) begin
          tx_v_d  = 1'b0;
          ix_v_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      word_q   <= '0;
      ipc_q    <= '0;
      tx_v_q   <= 1'b0;
      tx_q     <= '0;
      ix_v_q   <= 1'b0;
      ix_q     <= '0;
      nalloc_q <= '0;
      fstart_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q  <= state_d;
      pc_q     <= pc_d;
      word_q   <= word_d;
      ipc_q    <= ipc_d;
      tx_v_q   <= tx_v_d;
      tx_q     <= tx_d;
      ix_v_q   <= ix_v_d;
      ix_q     <= ix_d;
      nalloc_q <= nalloc_d;
      fstart_q <= fstart_d;
      done_q   <= done_d;
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign iss_valid   = (state_q == ST_ISSUE);
  assign iss_word    = word_q;
  assign iss_pc      = ipc_q;
  assign iss_tx_v    = tx_v_q;
  assign iss_tx      = tx_q;
  assign iss_ix_v    = ix_v_q;
  assign iss_ix      = ix_q;
  assign frag_start  = fstart_q;
  assign frag_nalloc = nalloc_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign done        = done_q;
  assign err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_frag_issue_ctrl.sv
// Randomized bench for frag_issue_ctrl: a program-level reference model walks
// instruction memory and predicts fetch addresses, issued bundles and outcome.
module tb_frag_issue_ctrl;

  localparam int PC_W = 10;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [PC_W-1:0] start_pc;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            iss_valid;
  logic            iss_ready;
  logic [31:0]     iss_word;
  logic [PC_W-1:0] iss_pc;
  logic            iss_tx_v;
  logic [15:0]     iss_tx;
  logic            iss_ix_v;
  logic [25:0]     iss_ix;
  logic            frag_start;
  logic [5:0]      frag_nalloc;
  logic            busy;
  logic            done;
  logic            err;

  frag_issue_ctrl #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_word    (iss_word),
    .iss_pc      (iss_pc),
    .iss_tx_v    (iss_tx_v),
    .iss_tx      (iss_tx),
    .iss_ix_v    (iss_ix_v),
    .iss_ix      (iss_ix),
    .frag_start  (frag_start),
    .frag_nalloc (frag_nalloc),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     word;
    logic [PC_W-1:0] pc;
    logic            tx_v;
    logic [15:0]     tx;
    logic            ix_v;
    logic [25:0]     ix;
  } bundle_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Instruction memory and reference-model expectations.
  logic [31:0]     mem [1024];
  bundle_t         exp_iss [$];
  logic [PC_W-1:0] exp_addr [$];
  int              exp_starts;
  logic            exp_done;
  logic            exp_err;
  logic [5:0]      exp_nalloc = '0;

  // Environment state.
  logic    chk_en = 1'b0;
  int      ready_mode = 0;
  int      cyc = 0;
  int      last_req_cyc = 0;
  int      stall_cnt = 0;
  int      stall_seen = 0;
  int      start_cnt = 0;
  int      done_cnt = 0;
  logic    prev_req = 1'b0;
  logic    prev_valid = 1'b0;
  logic    prev_ready = 1'b0;
  bundle_t prev_b;
  bundle_t last_iss;

  function automatic bundle_t observed();
    bundle_t b;
    b.word = iss_word;
    b.pc   = iss_pc;
    b.tx_v = iss_tx_v;
    b.tx   = iss_tx_v ? iss_tx : 16'h0;
    b.ix_v = iss_ix_v;
    b.ix   = iss_ix_v ? iss_ix : 26'h0;
    return b;
  endfunction

  function automatic logic [107:0] all_outs();
    return {imem_req, imem_addr, iss_valid, iss_word, iss_pc, iss_tx_v, iss_tx,
            iss_ix_v, iss_ix, frag_start, frag_nalloc, busy, done, err};
  endfunction

  // Reference model: executes the fragment at program level from spc.
  task automatic model(input logic [PC_W-1:0] spc);
    logic [PC_W-1:0] pc = spc;
    logic            tv = 1'b0, iv = 1'b0;
    logic [15:0]     tx = '0;
    logic [25:0]     ix = '0;
    logic [31:0]     w;
    bundle_t         b;
    exp_starts = 0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = mem[pc];
      exp_addr.push_back(pc);
      if (w[31:29] <= 3'd2) begin
        b.word = w; b.pc = pc;
        b.tx_v = tv; b.tx = tv ? tx : 16'h0;
        b.ix_v = iv; b.ix = iv ? ix : 26'h0;
        exp_iss.push_back(b);
        tv = 1'b0; iv = 1'b0;
      end else if (w[31:29] == 3'd3) begin
        if (tv) begin exp_err = 1'b1; break; end
        tv = 1'b1; tx = w[15:0];
      end else if (w[31:29] == 3'd4) begin
        if (iv) begin exp_err = 1'b1; break; end
        iv = 1'b1; ix = w[25:0];
      end else if (w[31:29] == 3'd5) begin
        if (tv || iv) begin exp_err = 1'b1; break; end
        if (w[28]) begin exp_done = 1'b1; break; end
        exp_starts++;
        exp_nalloc = w[5:0];
      end else begin
        exp_err = 1'b1;
        break;
      end
      pc = (pc == 10'h3FF) ? 10'h000 : pc + 10'h001;
    end
  endtask

  // Per-cycle environment: ready policy, memory responder and protocol monitor.
  initial begin
    bundle_t cur;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       iss_ready = 1'b1;
        1:       iss_ready = 1'($urandom_range(0, 1));
        default: iss_ready = iss_valid && (stall_cnt >= 5);
      endcase
      if (imem_req === 1'b1) imem_rdata = mem[imem_addr];
      else if (!prev_req) imem_rdata = $urandom;
      cur = observed();
      if (chk_en) begin
        if (imem_req) begin
          last_req_cyc = cyc;
          if (exp_addr.size() == 0) check("fetch_extra", 1, 0);
          else check("fetch_addr", imem_addr, exp_addr.pop_front());
        end
        if (iss_valid) check("req_during_issue", imem_req, 0);
        if (iss_valid && !prev_valid) check("issue_latency", cyc - last_req_cyc, 2);
        if (prev_valid && !prev_ready) check("issue_hold", {iss_valid, cur}, {1'b1, prev_b});
        if (iss_valid && iss_ready) begin
          last_iss = cur;
          if (exp_iss.size() == 0) check("issue_extra", 1, 0);
          else check("issue", cur, exp_iss.pop_front());
        end
        if (iss_valid && !iss_ready) stall_seen++;
        if (frag_start) start_cnt++;
        if (done) done_cnt++;
      end
      if (iss_valid && iss_ready) stall_cnt = 0;
      else if (iss_valid) stall_cnt++;
      prev_req   = (imem_req === 1'b1);
      prev_valid = (iss_valid === 1'b1);
      prev_ready = iss_ready;
      prev_b     = cur;
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_iss.delete();
    exp_addr.delete();
    exp_nalloc = '0;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  task automatic run(input logic [PC_W-1:0] spc);
    int k = 0;
    model(spc);
    start_cnt  = 0;
    done_cnt   = 0;
    stall_seen = 0;
    @(negedge clk);
    start_pc = spc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("start_ack", {busy, err}, 2'b10);
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      check("run_timeout", 0, 1);
      do_reset();
    end else begin
      repeat (2) @(negedge clk);
      check("done_pulses", done_cnt, exp_done);
      check("err", err, exp_err);
      check("busy_end", busy, 0);
      check("frag_starts", start_cnt, exp_starts);
      check("frag_nalloc", frag_nalloc, exp_nalloc);
      check("issues_left", exp_iss.size(), 0);
      check("fetches_left", exp_addr.size(), 0);
    end
  endtask

  function automatic logic [31:0] w_base();
    return {3'($urandom_range(0, 2)), 29'($urandom)};
  endfunction
  function automatic logic [31:0] w_t();   return {3'b011, 29'($urandom)}; endfunction
  function automatic logic [31:0] w_i();   return {3'b100, 29'($urandom)}; endfunction
  function automatic logic [31:0] w_fs();  return {4'b1010, 28'($urandom)}; endfunction
  function automatic logic [31:0] w_fe();  return {4'b1011, 28'($urandom)}; endfunction
  function automatic logic [31:0] w_ill(); return {2'b11, 30'($urandom)}; endfunction

  task automatic gen(input logic [PC_W-1:0] spc);
    logic [PC_W-1:0] a = spc;
    logic [31:0]     q [$];
    int              r;
    int              p;
    for (int n = 0; n < int'($urandom_range(1, 5)); n++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        p = $urandom_range(0, 3);
        if (p == 1) q.push_back(w_t());
        if (p == 2) q.push_back(w_i());
        if (p == 3) begin
          if ($urandom_range(0, 1) == 1) begin q.push_back(w_t()); q.push_back(w_i()); end
          else begin q.push_back(w_i()); q.push_back(w_t()); end
        end
        q.push_back(w_base());
      end else if (r < 15) q.push_back(w_fs());
      else if (r == 15) q.push_back(w_ill());
      else if (r == 16) begin q.push_back(w_t()); q.push_back(w_t()); q.push_back(w_base()); end
      else if (r == 17) begin q.push_back(w_i()); q.push_back(w_fs()); end
      else q.push_back(w_base());
    end
    if ($urandom_range(0, 15) == 0) q.push_back(w_t());
    q.push_back(w_fe());
    foreach (q[i]) begin
      mem[a] = q[i];
      a = a + 10'h001;
    end
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_pc   = '0;
    iss_ready  = 1'b0;
    imem_rdata = '0;
    foreach (mem[i]) mem[i] = 32'hB000_0000;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 108'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, err, imem_req, iss_valid}, 4'b0000);
    chk_en = 1'b1;

    // Fragment start, one ALU word, fragment end.
    mem[10'h010] = 32'hA000_0033;
    mem[10'h011] = 32'h0154_AAFC;
    mem[10'h012] = 32'hB000_0000;
    run(10'h010);
    check("basic_iss_pc", last_iss.pc, 10'h011);
    check("basic_nalloc", frag_nalloc, 6'h33);

    // Both prefixes folded into one base word.
    mem[10'h020] = 32'h6000_AAFC;
    mem[10'h021] = 32'h82AA_AAAA;
    mem[10'h022] = 32'h2B32_A5C7;
    mem[10'h023] = 32'hB000_0000;
    run(10'h020);
    check("pfx_tx", {last_iss.tx_v, last_iss.tx}, {1'b1, 16'hAAFC});
    check("pfx_ix", {last_iss.ix_v, last_iss.ix}, {1'b1, 26'h2AA_AAAA});
    check("pfx_cleared", {iss_tx_v, iss_ix_v}, 2'b00);

    // Back-pressure: ready held low for five cycles.
    ready_mode = 2;
    run(10'h020);
    check("stall_len", stall_seen, 5);
    ready_mode = 0;

    // Illegal word, then recovery from ERR.
    mem[10'h200] = 32'hFFFF_FFFF;
    run(10'h200);
    check("err_state", {err, busy}, 2'b10);
    run(10'h010);

    // Address wrap from 0x3FF to 0x000.
    mem[10'h3FF] = 32'h0000_1111;
    mem[10'h000] = 32'h2000_2222;
    mem[10'h001] = 32'hB000_0000;
    run(10'h3FF);
    check("wrap_iss_pc", last_iss.pc, 10'h000);

    // Randomized fragments with random back-pressure.
    for (int t = 0; t < 40; t++) begin
      logic [PC_W-1:0] spc;
      spc = 10'($urandom);
      gen(spc);
      ready_mode = $urandom_range(0, 1);
      run(spc);
    end
    ready_mode = 0;

    // Asynchronous reset while a bundle is waiting for acceptance.
    ready_mode = 2;
    @(negedge clk);
    chk_en   = 1'b0;
    start_pc = 10'h011;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    k = 0;
    while (!iss_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_reached_issue", iss_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_issue", all_outs(), 108'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", {busy, err, imem_req, iss_valid, done}, 5'b00000);
    exp_iss.delete();
    exp_addr.delete();
    exp_nalloc = '0;
    ready_mode = 0;
    chk_en = 1'b1;
    run(10'h010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
